// File: rtl/tb_ram_port_arbiter.sv
// Burst-limited round-robin arbiter sharing one RAM data port between two OBI requesters.
// Grants are combinational; responses follow the fixed 1-cycle RAM read latency.
module tb_ram_port_arbiter #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic             last_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rvalid_q;
    logic             owner_q;

    logic contended;
    logic sel;
    logic any_gnt;

    // sel picks the granted master; it rests on m0 when idle so the mux has a fixed default.
    always_comb begin
        contended = m0_req_i & m1_req_i;
        if (contended) begin
            sel = (cnt_q < CNT_W'(MAX_BURST)) ? last_q : ~last_q;
        end else begin
            sel = m1_req_i & ~m0_req_i;
        end
        any_gnt = rst_ni & (m0_req_i | m1_req_i);
    end

    assign m0_gnt_o = any_gnt & ~sel;
    assign m1_gnt_o = any_gnt & sel;

    assign ram_en_o    = any_gnt;
    assign ram_we_o    = any_gnt & (sel ? m1_we_i : m0_we_i);
    assign ram_addr_o  = rst_ni ? (sel ? m1_addr_i  : m0_addr_i)  : '0;
    assign ram_be_o    = rst_ni ? (sel ? m1_be_i    : m0_be_i)    : '0;
    assign ram_wdata_o = rst_ni ? (sel ? m1_wdata_i : m0_wdata_i) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q   <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            rvalid_q <= any_gnt;
            if (any_gnt) begin
                owner_q <= sel;
                // Only contended grants count toward the burst; an uncontended one restarts it.
                if (sel == last_q) begin
                    if (!contended) begin
                        cnt_q <= '0;
                    end else if (cnt_q != CNT_W'(MAX_BURST)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    last_q <= sel;
                    cnt_q  <= contended ? CNT_W'(1) : '0;
                end
            end
        end
    end

    assign m0_rvalid_o = rvalid_q & ~owner_q;
    assign m1_rvalid_o = rvalid_q & owner_q;
    assign m0_rdata_o  = ram_rdata_i;
    assign m1_rdata_o  = ram_rdata_i;

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({m0_gnt_o, m1_gnt_o}));
    a_gnt0_req: assert property (@(posedge clk_i) disable iff (!rst_ni) m0_gnt_o |-> m0_req_i);
    a_gnt1_req: assert property (@(posedge clk_i) disable iff (!rst_ni) m1_gnt_o |-> m1_req_i);
    a_rv0_past: assert property (@(posedge clk_i) disable iff (!rst_ni) m0_rvalid_o |-> $past(m0_gnt_o));
    a_rv1_past: assert property (@(posedge clk_i) disable iff (!rst_ni) m1_rvalid_o |-> $past(m1_gnt_o));

endmodule

// File: tb/tb_tb_ram_port_arbiter.sv
// Bench for the RAM port arbiter: directed scenarios plus random traffic against a
// run-length grant model and a reference memory.
module tb_tb_ram_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int MB = 2;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [3:0]    m0_be, m1_be;
    logic [DW-1:0] m0_wdata, m1_wdata;

    logic          a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid;
    logic [DW-1:0] a_m0_rdata, a_m1_rdata;
    logic          a_ram_en, a_ram_we;
    logic [AW-1:0] a_ram_addr;
    logic [3:0]    a_ram_be;
    logic [DW-1:0] a_ram_wdata, a_ram_rdata;

    logic          b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata;
    logic          b_ram_en, b_ram_we;
    logic [AW-1:0] b_ram_addr;
    logic [3:0]    b_ram_be;
    logic [DW-1:0] b_ram_wdata, b_ram_rdata;

    tb_ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req), .m0_gnt_o(a_m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(a_m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata),
        .ram_en_o(a_ram_en), .ram_addr_o(a_ram_addr), .ram_we_o(a_ram_we), .ram_be_o(a_ram_be),
        .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata)
    );

    // Strict round-robin instance sharing the same request inputs.
    tb_ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req), .m0_gnt_o(b_m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(b_m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
        .ram_en_o(b_ram_en), .ram_addr_o(b_ram_addr), .ram_we_o(b_ram_we), .ram_be_o(b_ram_be),
        .ram_wdata_o(b_ram_wdata), .ram_rdata_i(b_ram_rdata)
    );

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    always @(posedge clk_i) begin
        if (a_ram_en) begin
            if (a_ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (a_ram_be[b]) mem[a_ram_addr[7:0]][8*b +: 8] <= a_ram_wdata[8*b +: 8];
                end
            end
            a_ram_rdata <= mem[a_ram_addr[7:0]];
        end
    end

    always @(posedge clk_i) begin
        if (b_ram_en) b_ram_rdata <= ~{10'd0, b_ram_addr};
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Model: who was granted last and how many contended grants in a row it has taken.
    int            lastw, run, model_w;
    bit            exp_rv0, exp_rv1, exp_rd;
    logic [DW-1:0] exp_data;
    int            a_w, b_w;
    bit            a_rv0, a_rv1, b_rv0, b_rv1;
    logic [DW-1:0] a_rdata, b_rdata;

    task automatic model_reset();
        lastw = 0; run = 0; model_w = -1;
        exp_rv0 = 0; exp_rv1 = 0; exp_rd = 0; exp_data = '0;
    endtask

    // Called at a negedge with inputs applied; checks this cycle, advances to the next negedge.
    task automatic step();
        bit            c;
        int            w;
        logic [AW-1:0] ad;
        logic          we;
        logic [3:0]    be;
        logic [DW-1:0] wd;
        #1;
        c = m0_req && m1_req;
        if (c)           w = (run < MB) ? lastw : 1 - lastw;
        else if (m0_req) w = 0;
        else if (m1_req) w = 1;
        else             w = -1;
        a_w = a_m1_gnt ? 1 : (a_m0_gnt ? 0 : -1);
        b_w = b_m1_gnt ? 1 : (b_m0_gnt ? 0 : -1);
        a_rv0 = a_m0_rvalid; a_rv1 = a_m1_rvalid; a_rdata = a_m0_rvalid ? a_m0_rdata : a_m1_rdata;
        b_rv0 = b_m0_rvalid; b_rv1 = b_m1_rvalid; b_rdata = b_m0_rvalid ? b_m0_rdata : b_m1_rdata;

        chk("gnt0", a_m0_gnt, w == 0);
        chk("gnt1", a_m1_gnt, w == 1);
        chk("ram_en", a_ram_en, w >= 0);
        chk("rvalid0", a_m0_rvalid, exp_rv0);
        chk("rvalid1", a_m1_rvalid, exp_rv1);
        if (exp_rd && exp_rv0) chk("rdata0", a_m0_rdata, exp_data);
        if (exp_rd && exp_rv1) chk("rdata1", a_m1_rdata, exp_data);

        ad = (w == 1) ? m1_addr  : m0_addr;
        we = (w == 1) ? m1_we    : m0_we;
        be = (w == 1) ? m1_be    : m0_be;
        wd = (w == 1) ? m1_wdata : m0_wdata;
        chk("ram_addr", a_ram_addr, ad);
        if (w >= 0) begin
            chk("ram_we", a_ram_we, we);
            chk("ram_be", a_ram_be, be);
            chk("ram_wdata", a_ram_wdata, wd);
            $display("txn t=%0t m%0d %s addr=%0h be=%0h wdata=%0h", $time, w, we ? "wr" : "rd", ad, be, wd);
        end else begin
            chk("ram_we_idle", a_ram_we, 0);
        end

        exp_rv0 = (w == 0);
        exp_rv1 = (w == 1);
        exp_rd  = (w >= 0) && !we;
        if (exp_rd) exp_data = ref_mem[ad[7:0]];
        if (w >= 0 && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[ad[7:0]][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if (w >= 0) begin
            if (w == lastw) run = c ? run + 1 : 0;
            else begin
                lastw = w;
                run = c ? 1 : 0;
            end
        end
        model_w = w;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = 4'hF; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = 4'hF; m1_wdata = '0;
    endtask

    // Enters at a negedge, holds reset for a cycle with live requests, leaves at a negedge.
    task automatic do_reset();
        rst_ni = 0;
        model_reset();
        m0_req = 1; m0_we = 1; m0_addr = 22'h155; m0_wdata = 32'h1234_5678;
        m1_req = 1; m1_we = 1; m1_addr = 22'h2AA; m1_wdata = 32'h8765_4321;
        #1;
        chk("rst_gnt", {a_m0_gnt, a_m1_gnt}, 0);
        chk("rst_en_we", {a_ram_en, a_ram_we}, 0);
        chk("rst_addr", a_ram_addr, 0);
        chk("rst_wdata", a_ram_wdata, 0);
        chk("rst_rvalid", {a_m0_rvalid, a_m1_rvalid}, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1;
    endtask

    initial begin
        int exp2[8];
        idle_inputs();
        model_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
        end
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h40] = 32'hFFFF_FFFF;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        @(negedge clk_i);
        do_reset();

        // m0 single read
        m0_req = 1; m0_addr = 22'h10;
        step();
        chk("t1_gnt", a_w, 0);
        m0_req = 0;
        step();
        chk("t1_rv0", a_rv0, 1);
        chk("t1_rv1", a_rv1, 0);
        chk("t1_data", a_rdata, 32'hDEAD_BEEF);

        // Burst of two with both held
        do_reset();
        exp2 = '{0, 0, 1, 1, 0, 0, 1, 1};
        m0_req = 1; m0_addr = 22'h3; m1_req = 1; m1_addr = 22'h7;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_order", a_w, exp2[k]);
        end

        // Strict alternation on the MAX_BURST=1 instance
        do_reset();
        m0_req = 1; m0_addr = 22'h3; m1_req = 1; m1_addr = 22'h7;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t3_order", b_w, k % 2);
            if (k > 0) begin
                chk("t3_rv0", b_rv0, (k - 1) % 2 == 0);
                chk("t3_rv1", b_rv1, (k - 1) % 2 == 1);
                chk("t3_data", b_rdata, ((k - 1) % 2 == 0) ? ~32'h3 : ~32'h7);
            end
        end
        idle_inputs();
        step();

        // Partial write by m1 then read by m0
        m1_req = 1; m1_we = 1; m1_addr = 22'h40; m1_be = 4'b0011; m1_wdata = 32'hA5A5_A5A5;
        step();
        chk("t4_wgnt", a_w, 1);
        idle_inputs();
        m0_req = 1; m0_addr = 22'h40;
        step();
        m0_req = 0;
        step();
        chk("t4_rv0", a_rv0, 1);
        chk("t4_data", a_rdata, 32'hFFFF_A5A5);

        // Uncontended m1 run does not consume its burst budget
        do_reset();
        m1_req = 1; m1_addr = 22'h9;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_solo", a_w, 1);
        end
        m0_req = 1; m0_addr = 22'h4;
        exp2 = '{1, 1, 0, 0, 1, 1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_order", a_w, exp2[k]);
        end
        idle_inputs();

        // Reset right after an m0 grant drops the response
        m0_req = 1; m0_addr = 22'h10;
        #1;
        chk("t6_gnt", a_m0_gnt, 1);
        @(posedge clk_i);
        #1;
        rst_ni = 0;
        m0_req = 0;
        model_reset();
        @(negedge clk_i);
        #1;
        chk("t6_rv0", a_m0_rvalid, 0);
        chk("t6_rv1", a_m1_rvalid, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        m0_req = 1; m1_req = 1; m0_addr = 22'h2; m1_addr = 22'h5;
        step();
        chk("t6_first", a_w, 0);
        idle_inputs();
        m1_req = 1; m1_addr = 22'h5;
        step();
        step();
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 22'h2; m1_addr = 22'h5;
        step();
        chk("t6_favour", a_w, 0);
        idle_inputs();
        step();

        // Random traffic; a request stays stable until the model says it was granted
        for (int i = 0; i < 400; i++) begin
            if (m0_req && model_w == 0) m0_req = 0;
            if (m1_req && model_w == 1) m1_req = 0;
            if (!m0_req && $urandom_range(0, 2) != 0) begin
                m0_req = 1; m0_addr = 22'($urandom_range(0, 31)); m0_we = 1'($urandom_range(0, 1));
                m0_be = 4'($urandom); m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(0, 2) != 0) begin
                m1_req = 1; m1_addr = 22'($urandom_range(0, 31)); m1_we = 1'($urandom_range(0, 1));
                m1_be = 4'($urandom); m1_wdata = $urandom;
            end
            step();
        end
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
